eight_bit_int_squarer: RTL and testbench

Sequential integer squarer: the inverse of the integer square-root finder, using the same odd-number accumulation (1+3+5+…).
- Takes a W-bit unsigned operand and produces its 2W-bit square after operand+1 cycles, with a start/done handshake.
- Sits beside the square-root finder in the arithmetic block set; used to check root results and to generate SQ reference values.
- Single module: controller FSM plus datapath registers A, DEL, SQ, CNT, OUT.

---
 rtl/eight_bit_int_squarer_pkg.sv | 24 ++
 rtl/eight_bit_int_squarer_datapath.sv | 56 +++++
 rtl/eight_bit_int_squarer.sv | 81 ++++++++
 tb/tb_eight_bit_int_squarer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/eight_bit_int_squarer_pkg.sv
// Shared widths and state encoding for the squarer and square-root finder.
package eight_bit_int_squarer_pkg;

   localparam int unsigned W_DEFAULT  = 8;
   localparam int unsigned SQ_DEFAULT = 2 * W_DEFAULT;
   localparam int unsigned DEL_DEFAULT = W_DEFAULT + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Square / result width for a given operand width.
   function automatic int unsigned sq_width(input int unsigned w);
      return 2 * w;
   endfunction

   // Odd-increment width: must hold 2N+1 for the largest operand.
   function automatic int unsigned del_width(input int unsigned w);
      return w + 1;
   endfunction

endpackage

// File: rtl/eight_bit_int_squarer_datapath.sv
// Odd-number accumulation datapath: SQ += DEL, DEL += 2 until CNT reaches A.
module eight_bit_int_squarer_datapath
   import eight_bit_int_squarer_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 en_a,
   input  logic                 ld_add,
   input  logic                 en_acc,
   input  logic                 en_out,
   input  logic [W-1:0]         a,
   output logic [2*W-1:0]       q_out,
   output logic                 cnt_eq_a
);

   localparam int unsigned WQ = sq_width(W);
   localparam int unsigned WD = del_width(W);

   logic [W-1:0]  a_reg;
   logic [W-1:0]  cnt;
   logic [WD-1:0] del;
   logic [WQ-1:0] sq;

   // Operand capture, accumulation and result registers.
   always_ff @(posedge clk) begin
      if (!clr) begin
         a_reg <= '0;
         cnt   <= '0;
         del   <= '0;
         sq    <= '0;
         q_out <= '0;
      end else begin
         if (en_a) begin
            a_reg <= a;
         end
         if (ld_add) begin
            sq  <= '0;
            del <= WD'(1);
            cnt <= '0;
         end else if (en_acc) begin
            sq  <= sq + WQ'(del);
            del <= del + WD'(2);
            cnt <= cnt + W'(1);
         end
         if (en_out) begin
            q_out <= sq;
         end
      end
   end

   // CNT never passes A, so equality marks the final sum.
   assign cnt_eq_a = (cnt == a_reg);

endmodule

// File: rtl/eight_bit_int_squarer.sv
// Sequential integer squarer: controller FSM around the accumulation datapath.
module eight_bit_int_squarer
   import eight_bit_int_squarer_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [W-1:0]         a,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [2*W-1:0]       q_out
);

   state_t state;
   logic   cnt_eq_a;
   logic   accept;
   logic   en_a;
   logic   ld_add;
   logic   en_acc;
   logic   en_out;

   // Datapath strobes decoded from the registered state.
   assign accept = (state == IDLE) && start;
   assign en_a   = accept;
   assign ld_add = accept;
   assign en_acc = (state == ADD) && !cnt_eq_a;
   assign en_out = (state == ADD) && cnt_eq_a;

   // Controller: state plus registered busy/done flags.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= ADD;
                  busy  <= 1'b1;
               end
            end
            ADD: begin
               if (cnt_eq_a) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   eight_bit_int_squarer_datapath #(
      .W (W)
   ) u_dp (
      .clk      (clk),
      .clr      (clr),
      .en_a     (en_a),
      .ld_add   (ld_add),
      .en_acc   (en_acc),
      .en_out   (en_out),
      .a        (a),
      .q_out    (q_out),
      .cnt_eq_a (cnt_eq_a)
   );

endmodule

// File: tb/tb_eight_bit_int_squarer.sv
// Self-checking bench for eight_bit_int_squarer with a result scoreboard.
module tb_eight_bit_int_squarer;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [7:0]  a;
   logic        busy;
   logic        done;
   logic [15:0] q_out;

   int checks = 0;
   int errors = 0;
   int unsigned sb[$];
   logic [15:0] last_q;

   eight_bit_int_squarer dut (
      .clk   (clk),
      .clr   (clr),
      .a     (a),
      .start (start),
      .busy  (busy),
      .done  (done),
      .q_out (q_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive a start in IDLE; returns in the cycle after acceptance edge T0.
   task automatic launch(input int unsigned n);
      a     = 8'(n);
      start = 1'b1;
      sb.push_back(n * n);
      tick();
      start = 1'b0;
      a     = 8'($urandom);
      check("busy_after_t0", 32'(busy), 32'd1);
      check("done_after_t0", 32'(done), 32'd0);
   endtask

   // Wait (bounded) for done; expects it exactly ticks_exp edges later.
   task automatic wait_done(input int unsigned ticks_exp, input string tag);
      int unsigned cnt = 0;
      bit got = 1'b0;
      int unsigned exp;
      while (!got && cnt < ticks_exp + 4) begin
         tick();
         cnt++;
         if (done === 1'b1) begin
            got = 1'b1;
         end else begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_q_held"}, 32'(q_out), 32'(last_q));
         end
      end
      check({tag, "_latency"}, cnt, ticks_exp);
      if (got) begin
         check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
         check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_q_out"}, 32'(q_out), exp);
            last_q = 16'(exp);
         end
      end
   endtask

   // Step out of DONE and confirm the pulse was one cycle wide.
   task automatic finish_op(input string tag);
      tick();
      check({tag, "_done_width"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      check({tag, "_q_hold"}, 32'(q_out), 32'(last_q));
   endtask

   initial begin
      int unsigned dummy;
      clr   = 1'b0;
      start = 1'b0;
      a     = 8'd0;
      last_q = 16'd0;
      repeat (2) tick();
      // Reset must win over a concurrent start.
      start = 1'b1;
      a     = 8'd9;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q_out", 32'(q_out), 32'd0);
      start = 1'b0;
      clr   = 1'b1;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // Operand 0: one ADD cycle then DONE.
      launch(0);
      wait_done(1, "a0");
      finish_op("a0");

      // Operand 5.
      launch(5);
      wait_done(6, "a5");
      finish_op("a5");

      // Largest operand.
      launch(255);
      wait_done(256, "a255");
      finish_op("a255");

      // Starts during ADD and DONE are ignored.
      launch(7);
      tick();
      a     = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
      wait_done(6, "a7");
      a     = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_done_start_busy", 32'(busy), 32'd0);
      check("ign_done_start_done", 32'(done), 32'd0);
      check("ign_q_out", 32'(q_out), 32'd49);
      launch(3);
      wait_done(4, "a3");
      finish_op("a3");

      // Reset aborts a computation in flight.
      launch(200);
      repeat (49) tick();
      check("abort_busy_before", 32'(busy), 32'd1);
      clr = 1'b0;
      tick();
      clr = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_q_out", 32'(q_out), 32'd0);
      dummy = sb.pop_back();
      last_q = 16'd0;
      repeat (3) begin
         tick();
         check("abort_no_done", 32'(done), 32'd0);
      end
      launch(12);
      wait_done(13, "a12");
      finish_op("a12");

      // Back-to-back sweep of every operand.
      for (int n = 0; n < 256; n++) begin
         launch(n);
         wait_done(n + 1, "sweep");
         finish_op("sweep");
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
